// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
//   shift_op_t  : operation encoding (ROR, ROL, SRL, SRA)
//   bit_reverse : reverses the low `width` bits of a word (upper bits return 0)
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_ROR = 2'b00,
        OP_ROL = 2'b01,
        OP_SRL = 2'b10,
        OP_SRA = 2'b11
    } shift_op_t;

    // Widest operand bit_reverse can handle; callers zero-extend into this.
    localparam int unsigned MaxDataWidth = 256;

    function automatic logic [MaxDataWidth-1:0] bit_reverse(
        input logic [MaxDataWidth-1:0] data,
        input int unsigned             width
    );
        logic [MaxDataWidth-1:0] rev;
        for (int unsigned i = 0; i < MaxDataWidth; i++) begin
            rev[i] = data[MaxDataWidth-1-i];
        end
        // Full-width reversal parks the operand in the top bits; bring it back down.
        return rev >> (MaxDataWidth - width);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational log-shifter stage: optionally moves the word right by DIST.
// Ports:
//   data_i : operand
//   en_i   : apply this stage's shift
//   op_i   : operation; selects the fill for the vacated top DIST bits
//   sign_i : sign bit of the original operand, used as SRA fill
//   data_o : result
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DIST       = 1
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  en_i,
    input  shift_op_t             op_i,
    input  logic                  sign_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DIST-1:0] fill;

    always_comb begin
        case (op_i)
            OP_SRL:  fill = '0;
            OP_SRA:  fill = {DIST{sign_i}};
            // ROR and ROL (already bit-reversed upstream) both wrap around.
            default: fill = data_i[DIST-1:0];
        endcase
        data_o = en_i ? {fill, data_i[DATA_WIDTH-1:DIST]} : data_i;
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: ROR / ROL / SRL / SRA with valid/ready on both sides.
// The right-only log shifter is split into register ranks of STAGES_PER_RANK stages.
// ROL is handled as reverse -> ROR -> reverse.
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake; in_data, in_amt, in_op are the operand
//   out_valid/out_ready  : output handshake; out_data is the result
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned SHIFT_WIDTH     = $clog2(DATA_WIDTH),
    parameter int unsigned STAGES_PER_RANK = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [SHIFT_WIDTH-1:0] in_amt,
    input  logic [1:0]             in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data
);

    localparam int unsigned NRank    = (SHIFT_WIDTH + STAGES_PER_RANK - 1) / STAGES_PER_RANK;
    localparam int unsigned LastRank = NRank - 1;

    // Rank registers
    logic                   valid_q [NRank];
    logic [DATA_WIDTH-1:0]  data_q  [NRank];
    shift_op_t              op_q    [NRank];
    logic                   sign_q  [NRank];
    logic [SHIFT_WIDTH-1:0] amt_q   [NRank];

    // Rank inputs (predecessor rank, or the in_* operand for rank 0)
    logic                   rin_valid [NRank];
    logic [DATA_WIDTH-1:0]  rin_data  [NRank];
    shift_op_t              rin_op    [NRank];
    logic                   rin_sign  [NRank];
    logic [SHIFT_WIDTH-1:0] rin_amt   [NRank];

    logic [DATA_WIDTH-1:0]  data_d [NRank];
    logic [DATA_WIDTH-1:0]  st_out [SHIFT_WIDTH];

    logic [MaxDataWidth-1:0] rev_in_full;
    logic [MaxDataWidth-1:0] rev_out_full;
    logic                    advance;

    // Global stall: every rank moves together or holds together.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign rev_in_full  = bit_reverse(MaxDataWidth'(in_data), DATA_WIDTH);
    assign rev_out_full = bit_reverse(MaxDataWidth'(data_q[LastRank]), DATA_WIDTH);

    always_comb begin
        rin_valid[0] = in_valid;
        rin_op[0]    = shift_op_t'(in_op);
        rin_data[0]  = (shift_op_t'(in_op) == OP_ROL) ? rev_in_full[DATA_WIDTH-1:0] : in_data;
        rin_sign[0]  = in_data[DATA_WIDTH-1];
        rin_amt[0]   = in_amt;
        for (int unsigned k = 1; k < NRank; k++) begin
            rin_valid[k] = valid_q[k-1];
            rin_data[k]  = data_q[k-1];
            rin_op[k]    = op_q[k-1];
            rin_sign[k]  = sign_q[k-1];
            rin_amt[k]   = amt_q[k-1];
        end
    end

    // Stage s sits in rank s / STAGES_PER_RANK; the first stage of a rank takes
    // the rank input, the others chain from the previous stage.
    for (genvar s = 0; s < SHIFT_WIDTH; s++) begin : g_stage
        localparam int unsigned Rank = s / STAGES_PER_RANK;
        logic [DATA_WIDTH-1:0] stage_in;

        if (s % STAGES_PER_RANK == 0) begin : g_first
            assign stage_in = rin_data[Rank];
        end else begin : g_chain
            assign stage_in = st_out[s-1];
        end

        shift_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .DIST       (2 ** s)
        ) u_stage (
            .data_i (stage_in),
            .en_i   (rin_amt[Rank][s]),
            .op_i   (rin_op[Rank]),
            .sign_i (rin_sign[Rank]),
            .data_o (st_out[s])
        );
    end

    for (genvar k = 0; k < NRank; k++) begin : g_rank_out
        localparam int unsigned End =
            ((k + 1) * STAGES_PER_RANK < SHIFT_WIDTH) ? (k + 1) * STAGES_PER_RANK : SHIFT_WIDTH;
        assign data_d[k] = st_out[End-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NRank; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                op_q[k]    <= OP_ROR;
                sign_q[k]  <= 1'b0;
                amt_q[k]   <= '0;
            end
        end else if (advance) begin
            for (int unsigned k = 0; k < NRank; k++) begin
                valid_q[k] <= rin_valid[k];
                data_q[k]  <= data_d[k];
                op_q[k]    <= rin_op[k];
                sign_q[k]  <= rin_sign[k];
                amt_q[k]   <= rin_amt[k];
            end
        end
    end

    assign out_valid = valid_q[LastRank];
    // ROL results are still bit-reversed in the last rank; undo that here.
    assign out_data  = (op_q[LastRank] == OP_ROL) ? rev_out_full[DATA_WIDTH-1:0]
                                                  : data_q[LastRank];

    // Consumed amount bits, last-rank sign/amt and reversal headroom are
    // intentionally left unused.
    logic unused_bits;
    always_comb begin
        unused_bits = ^{rev_in_full, rev_out_full, sign_q[LastRank]};
        for (int unsigned k = 0; k < NRank; k++) begin
            unused_bits = unused_bits ^ (^rin_amt[k]) ^ (^amt_q[k]);
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (defaults: 16-bit, 2 ranks).
module tb_pipelined_barrel_shifter;

    localparam logic [1:0] Ror = 2'b00;
    localparam logic [1:0] Rol = 2'b01;
    localparam logic [1:0] Srl = 2'b10;
    localparam logic [1:0] Sra = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int tests = 0;
    int fails = 0;
    logic [15:0] sc[$];

    pipelined_barrel_shifter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ror16(input logic [15:0] d, input logic [3:0] a);
        logic [31:0] t;
        t = {d, d} >> a;
        return t[15:0];
    endfunction

    // Present an operand and keep it until accepted; the expected result is
    // queued once acceptance is certain for the coming edge.
    task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [3:0] a,
                        input logic [15:0] exp);
        int waited = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk1("send_accept", in_ready, 1'b1);
        if (in_ready) sc.push_back(exp);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_op    = 2'($urandom);
        in_amt   = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sc.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("drain_empty", sc.size() == 0, 1'b1);
    endtask

    // Output monitor: pops on each output transfer, checks hold behaviour.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                if (sc.size() == 0) begin
                    chk1("spurious_out", out_valid, 1'b0);
                end else begin
                    chk16("result", out_data, sc.pop_front());
                end
            end
            if (out_valid && !out_ready) begin
                chk1("in_ready_hold", in_ready, 1'b0);
                if (sc.size() != 0) chk16("hold_data", out_data, sc[0]);
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = Ror;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk16("rst_out_data", out_data, 16'h0000);
        chk1("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First operand with latency check: valid in the 2nd cycle after transfer
        send(Ror, 16'h8001, 4'd1, 16'hC000);
        idle();
        @(negedge clk);
        chk1("lat_cycle1", out_valid, 1'b0);
        @(negedge clk);
        chk1("lat_cycle2", out_valid, 1'b1);
        drain();

        // Directed operations, back to back
        send(Ror, 16'h1234, 4'd4,  16'h4123);
        send(Rol, 16'h8001, 4'd4,  16'h0018);
        send(Rol, 16'h1234, 4'd15, 16'h091A);
        send(Srl, 16'hF000, 4'd4,  16'h0F00);
        send(Sra, 16'hF000, 4'd4,  16'hFF00);
        send(Sra, 16'h7000, 4'd15, 16'h0000);
        send(Ror, 16'hA5C3, 4'd0,  16'hA5C3);
        send(Rol, 16'hA5C3, 4'd0,  16'hA5C3);
        send(Srl, 16'hA5C3, 4'd0,  16'hA5C3);
        send(Sra, 16'hA5C3, 4'd0,  16'hA5C3);
        idle();
        drain();

        // Streaming with backpressure in cycles 3..5
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(Ror, 16'h1357, 4'(i), ror16(16'h1357, 4'(i)));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Reset with two operands in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(Srl, 16'hFFFF, 4'd1, 16'h7FFF);
        send(Ror, 16'h00FF, 4'd4, 16'hF00F);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        sc.delete();
        @(posedge clk);
        @(negedge clk);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk16("midrst_out_data", out_data, 16'h0000);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("no_ghost", out_valid, 1'b0);
        end

        // Fresh operand after reset completes with normal latency
        send(Ror, 16'hA5C3, 4'd8, 16'hC3A5);
        idle();
        @(negedge clk);
        chk1("post_rst_lat1", out_valid, 1'b0);
        @(negedge clk);
        chk1("post_rst_lat2", out_valid, 1'b1);
        drain();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
